// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and framing constants.
// Intended to be reused by the companion transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_DEF_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling at a fixed baud.
// Holds the last good byte for the LED stage and strobes valid/error per frame.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      Clk,
    input  logic                      RstN,
    input  logic                      RxIn,
    output logic [UART_DATA_BITS-1:0] DataOut,
    output logic                      DataValid,
    output logic                      LEDEn,
    output logic                      FrameErr,
    output logic                      Busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (Clk),
        .rst_n (RstN),
        .d     (RxIn),
        .q     (rx_s)
    );

    rx_state_t                 state, state_nx;
    logic [CW-1:0]             cnt, cnt_nx;
    logic [2:0]                idx, idx_nx;
    logic [UART_DATA_BITS-1:0] sh, sh_nx, data_nx;
    logic                      valid_nx, err_nx, led_nx;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            FrameErr  <= 1'b0;
            LEDEn     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            sh        <= sh_nx;
            DataOut   <= data_nx;
            DataValid <= valid_nx;
            FrameErr  <= err_nx;
            LEDEn     <= led_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sh_nx    = sh;
        data_nx  = DataOut;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        led_nx   = LEDEn;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                cnt_nx = cnt + CW'(1);
                // A line that is high again at mid start bit was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    sh_nx  = {rx_s, sh[UART_DATA_BITS-1:1]};
                    if (idx == IDX_LAST) state_nx = STOP;
                    else                 idx_nx   = idx + 3'd1;
                end
            end
            STOP: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = WAITHI;
                    if (rx_s) begin
                        data_nx  = sh;
                        valid_nx = 1'b1;
                        led_nx   = 1'b1;
                    end else begin
                        err_nx   = 1'b1;
                        led_nx   = 1'b0;
                    end
                end
            end
            WAITHI: begin
                // A line stuck low after a bad stop bit must not look like a start bit.
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized bench for uart_rx_byte: frames are driven bit-by-bit and the
// resulting strobes are compared against events predicted from the frame rules.
module tb_uart_rx_byte;

    localparam int CPB = 8;
    localparam int HB  = CPB / 2;
    // Strobe is high in cycle 3+HB+9*CPB counted from the edge that first sees RxIn low.
    localparam int OFS = 3 + HB + 9 * CPB - 1;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       RxIn;
    logic [7:0] DataOut;
    logic       DataValid, LEDEn, FrameErr, Busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .RxIn      (RxIn),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .LEDEn     (LEDEn),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] d;
        logic       led;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    // Reference state: last good byte and LED enable level.
    logic [7:0] m_data = 8'h00;
    logic       m_led  = 1'b0;

    always @(negedge Clk) begin
        if (RstN && (DataValid || FrameErr)) begin
            ev_t e;
            chk("strobe_excl", {31'b0, DataValid & FrameErr}, 32'd0);
            e.t   = cyc;
            e.err = FrameErr;
            e.d   = DataOut;
            e.led = LEDEn;
            got_q.push_back(e);
        end
    end

    task automatic drive_bit(input logic b, input int n);
        RxIn = b;
        repeat (n) @(negedge Clk);
    endtask

    // Called at a negedge; the following rising edge is cycle 0 of the frame.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.t = cyc + 1 + OFS;
        if (stop_ok) begin
            m_data = b;
            m_led  = 1'b1;
        end else begin
            m_led  = 1'b0;
        end
        e.err = !stop_ok;
        e.d   = m_data;
        e.led = m_led;
        exp_q.push_back(e);
        drive_bit(1'b0, CPB);
        for (int k = 0; k < 8; k++) drive_bit(b[k], CPB);
        drive_bit(stop_ok, CPB);
    endtask

    task automatic drain(input string tag);
        chk({tag, " n_events"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev_t ge, ee;
            ge = got_q.pop_front();
            ee = exp_q.pop_front();
            chk({tag, " time"},  ge.t,   ee.t);
            chk({tag, " kind"},  ge.err, ee.err);
            chk({tag, " data"},  ge.d,   ee.d);
            chk({tag, " leden"}, ge.led, ee.led);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " DataOut"},   DataOut,   32'd0);
        chk({tag, " DataValid"}, DataValid, 32'd0);
        chk({tag, " LEDEn"},     LEDEn,     32'd0);
        chk({tag, " FrameErr"},  FrameErr,  32'd0);
        chk({tag, " Busy"},      Busy,      32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         rise_n, fall_n;

        RstN = 1'b0;
        RxIn = 1'b1;
        #3 chk_all_zero("reset");
        repeat (3) @(negedge Clk);
        RstN = 1'b1;
        repeat (4) @(negedge Clk);

        // Single good frame.
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        chk("a5 DataOut", DataOut, 32'hA5);
        chk("a5 LEDEn", LEDEn, 32'd1);
        drain("a5");

        // Reset asserted asynchronously during data bit 3.
        b = 8'h77;
        drive_bit(1'b0, CPB);
        for (int k = 0; k < 3; k++) drive_bit(b[k], CPB);
        RxIn = b[3];
        repeat (3) @(negedge Clk);
        #2 RstN = 1'b0;
        #1 chk_all_zero("midrst");
        RxIn = 1'b1;
        repeat (2) @(negedge Clk);
        RstN   = 1'b1;
        m_data = 8'h00;
        m_led  = 1'b0;
        drive_bit(1'b1, 30);
        drain("midrst idle");
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        drain("after_rst");

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        drain("b2b");

        // Start-bit glitch: low for 3 cycles only.
        rise_n = -1;
        fall_n = -1;
        RxIn   = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge Clk);
            if (n == 3) RxIn = 1'b1;
            if (Busy && rise_n < 0) rise_n = n;
            if (!Busy && rise_n >= 0 && fall_n < 0) fall_n = n;
        end
        chk("glitch busy_rise", rise_n, 32'd3);
        chk("glitch busy_fall", fall_n, 32'd7);
        drain("glitch");

        // Framing error, line held low afterwards.
        send_frame(8'h55, 1'b0);
        drive_bit(1'b0, 20);
        chk("ferr held_busy", Busy, 32'd1);
        chk("ferr LEDEn", LEDEn, 32'd0);
        drive_bit(1'b1, 4);
        chk("ferr back_idle", Busy, 32'd0);
        drain("ferr");
        send_frame(8'h12, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        chk("recover LEDEn", LEDEn, 32'd1);
        drain("recover");

        // Random frames with occasional bad stop bits and random gaps.
        for (int f = 0; f < 40; f++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (!ok) begin
                drive_bit(1'b0, $urandom_range(0, 15));
                drive_bit(1'b1, $urandom_range(1, 6));
            end else begin
                drive_bit(1'b1, $urandom_range(0, 20));
            end
        end
        drive_bit(1'b1, 2 * CPB);
        chk("rand DataOut", DataOut, m_data);
        chk("rand LEDEn", LEDEn, m_led);
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
